// File: rtl/quad_enc_gen.sv
// Multi-channel quadrature encoder pattern generator. Each channel accepts a
// command (edge count, direction, quarter-period) and emits registered A/B/Z
// waveforms while tracking a signed position.
// Latency: first edge qprd cycles after accept; cmd_ready low while a channel runs.
// Optional index pulse generation: define QUAD_ENC_GEN_INDEX_EN to build the
// per-channel index counter; otherwise z is tied low.

module quad_enc_gen #(
  parameter int CH    = 2,
  parameter int STEPW = 16,
  parameter int PRDW  = 16,
  parameter int POSW  = 32,
  parameter int CPR   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       cmd_valid,
  output logic [CH-1:0]       cmd_ready,
  input  logic [CH-1:0]       cmd_ccw,
  input  logic [CH*STEPW-1:0] cmd_steps,
  input  logic [CH*PRDW-1:0]  cmd_qprd,
  input  logic [CH-1:0]       abort,
  output logic [CH-1:0]       a,
  output logic [CH-1:0]       b,
  output logic [CH-1:0]       z,
  output logic [CH-1:0]       busy,
  output logic [CH-1:0]       done,
  output logic [CH*POSW-1:0]  pos
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Elaboration-time sanity on the configuration.
  if (CH < 1 || CH > 8) begin : g_bad_ch
    $error("quad_enc_gen: CH must be in 1..8");
  end
  if (CPR < 4 || (CPR & (CPR - 1)) != 0) begin : g_bad_cpr
    $error("quad_enc_gen: CPR must be a power of two and at least 4");
  end

`ifdef QUAD_ENC_GEN_INDEX_EN
  localparam int IDXW = $clog2(CPR);
`endif

  for (genvar i = 0; i < CH; i++) begin : g_ch

    // Per-channel state
    state_t           state_q, state_d;
    logic [STEPW-1:0] steps_q, steps_d;   // edges still to emit
    logic [PRDW-1:0]  qprd_q,  qprd_d;    // latched quarter-period (never 0)
    logic [PRDW-1:0]  timer_q, timer_d;   // clocks until next edge
    logic             ccw_q,   ccw_d;
    logic             a_q,     a_d;
    logic             b_q,     b_d;
    logic             done_q,  done_d;
    logic [POSW-1:0]  pos_q,   pos_d;
`ifdef QUAD_ENC_GEN_INDEX_EN
    logic [IDXW-1:0]  idx_q,   idx_d;     // position within one revolution
    logic             z_q,     z_d;
`endif

    // Command slice for this channel
    logic [STEPW-1:0] in_steps;
    logic [PRDW-1:0]  in_qprd;
    logic [PRDW-1:0]  in_qprd_eff;
    logic             ready_c;
    logic             accept;
    logic             step_en;
    logic             last_edge;

    assign in_steps    = cmd_steps[i*STEPW +: STEPW];
    assign in_qprd     = cmd_qprd[i*PRDW +: PRDW];
    // A zero quarter-period would never expire; run it as one clock per edge.
    assign in_qprd_eff = (in_qprd == '0) ? PRDW'(1) : in_qprd;
    assign accept      = cmd_valid[i] && ready_c;
    // An edge fires when the timer is at its last count; abort wins over it.
    assign step_en     = (state_q == RUN) && (timer_q == PRDW'(1)) && !abort[i];
    assign last_edge   = step_en && (steps_q == STEPW'(1));

    // State register: async reset returns the channel to idle with outputs low
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        steps_q <= '0;
        qprd_q  <= PRDW'(1);
        timer_q <= '0;
        ccw_q   <= 1'b0;
        a_q     <= 1'b0;
        b_q     <= 1'b0;
        done_q  <= 1'b0;
        pos_q   <= '0;
`ifdef QUAD_ENC_GEN_INDEX_EN
        idx_q   <= '0;
        z_q     <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        steps_q <= steps_d;
        qprd_q  <= qprd_d;
        timer_q <= timer_d;
        ccw_q   <= ccw_d;
        a_q     <= a_d;
        b_q     <= b_d;
        done_q  <= done_d;
        pos_q   <= pos_d;
`ifdef QUAD_ENC_GEN_INDEX_EN
        idx_q   <= idx_d;
        z_q     <= z_d;
`endif
      end
    end

    // Next-state: zero-step commands never leave idle; abort or the final edge end a run
    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE: begin
          if (accept && (in_steps != '0)) state_d = RUN;
        end
        RUN: begin
          if (abort[i] || last_edge) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Datapath: latch commands, count down the timer, advance the quadrature phase
    always_comb begin
      steps_d = steps_q;
      qprd_d  = qprd_q;
      timer_d = timer_q;
      ccw_d   = ccw_q;
      a_d     = a_q;
      b_d     = b_q;
      done_d  = 1'b0;
      pos_d   = pos_q;
`ifdef QUAD_ENC_GEN_INDEX_EN
      idx_d   = idx_q;
      z_d     = z_q;
`endif
      if (accept) begin
        steps_d = in_steps;
        ccw_d   = cmd_ccw[i];
        qprd_d  = in_qprd_eff;
        timer_d = in_qprd_eff;
        // An empty command completes immediately without touching the outputs.
        done_d  = (in_steps == '0);
      end else if (step_en) begin
        timer_d = qprd_q;
        steps_d = steps_q - STEPW'(1);
        done_d  = (steps_q == STEPW'(1));
        // Gray sequence: forward toggles A when A==B, else B; reverse is the mirror.
        if ((a_q == b_q) ^ ccw_q) a_d = ~a_q;
        else                      b_d = ~b_q;
        pos_d = ccw_q ? (pos_q - POSW'(1)) : (pos_q + POSW'(1));
`ifdef QUAD_ENC_GEN_INDEX_EN
        // Counter width is log2(CPR), so natural wrap gives modulo-CPR counting.
        idx_d = ccw_q ? (idx_q - IDXW'(1)) : (idx_q + IDXW'(1));
        z_d   = (idx_d == '0);
`endif
      end else if (state_q == RUN && !abort[i]) begin
        timer_d = timer_q - PRDW'(1);
      end
    end

    // Outputs: handshake is combinational, everything else comes straight from flops
    always_comb begin
      ready_c = (state_q == IDLE) && !abort[i];
    end

    assign cmd_ready[i]            = ready_c;
    assign a[i]                    = a_q;
    assign b[i]                    = b_q;
    assign busy[i]                 = (state_q == RUN);
    assign done[i]                 = done_q;
    assign pos[i*POSW +: POSW]     = pos_q;
`ifdef QUAD_ENC_GEN_INDEX_EN
    assign z[i]                    = z_q;
`else
    assign z[i]                    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_quad_enc_gen.sv
// Directed bench for quad_enc_gen in its default two-channel configuration
// (index generation not enabled, so z must stay low throughout).
module tb_quad_enc_gen;

  logic        clk;
  logic        rst;
  logic [1:0]  cmd_valid;
  logic [1:0]  cmd_ready;
  logic [1:0]  cmd_ccw;
  logic [31:0] cmd_steps;
  logic [31:0] cmd_qprd;
  logic [1:0]  abort;
  logic [1:0]  a;
  logic [1:0]  b;
  logic [1:0]  z;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [63:0] pos;

  int total;
  int passed;
  int fails;

  quad_enc_gen dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ccw   (cmd_ccw),
    .cmd_steps (cmd_steps),
    .cmd_qprd  (cmd_qprd),
    .abort     (abort),
    .a         (a),
    .b         (b),
    .z         (z),
    .busy      (busy),
    .done      (done),
    .pos       (pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ab(input int ch);
    return {a[ch], b[ch]};
  endfunction

  logic [1:0]  cw_tab  [4];
  logic [1:0]  ccw_tab [4];
  logic [31:0] ep;
  int          e0;
  int          e1;

  initial begin
    total = 0; passed = 0; fails = 0;
    cw_tab  = '{2'b00, 2'b10, 2'b11, 2'b01};
    ccw_tab = '{2'b00, 2'b01, 2'b11, 2'b10};

    rst = 1'b1; cmd_valid = '0; cmd_ccw = '0; cmd_steps = '0; cmd_qprd = '0; abort = '0;
    #12;
    check("rst_a", a, 2'b00);
    check("rst_b", b, 2'b00);
    check("rst_z", z, 2'b00);
    check("rst_busy", busy, 2'b00);
    check("rst_done", done, 2'b00);
    check("rst_pos", pos, 64'd0);
    #5 rst = 1'b0;
    tick();
    check("ready_after_rst", cmd_ready, 2'b11);

    // ch0: 8 steps qprd 4 forward; ch1: 4 steps qprd 3 reverse, concurrently
    cmd_valid = 2'b11; cmd_ccw = 2'b10;
    cmd_steps = {16'd4, 16'd8}; cmd_qprd = {16'd3, 16'd4};
    tick();
    // Scramble the command inputs: running commands must not see this
    cmd_valid = 2'b00; cmd_steps = {16'd99, 16'd99}; cmd_qprd = {16'd1, 16'd1}; cmd_ccw = 2'b01;
    check("run_busy", busy, 2'b11);
    check("run_ready", cmd_ready, 2'b00);
    for (int n = 1; n <= 33; n++) begin
      tick();
      e0 = (n / 4 > 8) ? 8 : n / 4;
      e1 = (n / 3 > 4) ? 4 : n / 3;
      check($sformatf("c0_ab_%0d", n), ab(0), cw_tab[e0 % 4]);
      ep = e0;
      check($sformatf("c0_pos_%0d", n), pos[31:0], ep);
      check($sformatf("c0_done_%0d", n), done[0], (n == 32));
      check($sformatf("c0_busy_%0d", n), busy[0], (n < 32));
      check($sformatf("c1_ab_%0d", n), ab(1), ccw_tab[e1 % 4]);
      ep = -e1;
      check($sformatf("c1_pos_%0d", n), pos[63:32], ep);
      check($sformatf("c1_done_%0d", n), done[1], (n == 12));
      check($sformatf("z_%0d", n), z, 2'b00);
    end

    // Zero-step command: done next cycle, never busy, outputs untouched
    cmd_valid = 2'b01; cmd_ccw = 2'b00; cmd_steps = {16'd0, 16'd0}; cmd_qprd = {16'd0, 16'd4};
    tick();
    cmd_valid = 2'b00;
    check("zs_done", done[0], 1'b1);
    check("zs_busy", busy[0], 1'b0);
    tick();
    check("zs_done_off", done[0], 1'b0);
    check("zs_busy2", busy[0], 1'b0);
    check("zs_ab", ab(0), 2'b00);
    check("zs_pos", pos[31:0], 32'd8);

    // qprd 0 runs as 1: two edges on consecutive cycles
    cmd_valid = 2'b01; cmd_steps = {16'd0, 16'd2}; cmd_qprd = {16'd0, 16'd0};
    tick();
    cmd_valid = 2'b00;
    check("q0_busy", busy[0], 1'b1);
    tick();
    check("q0_ab1", ab(0), 2'b10);
    check("q0_pos1", pos[31:0], 32'd9);
    check("q0_done1", done[0], 1'b0);
    tick();
    check("q0_ab2", ab(0), 2'b11);
    check("q0_pos2", pos[31:0], 32'd10);
    check("q0_done2", done[0], 1'b1);
    check("q0_busy2", busy[0], 1'b0);

    // ch1 from 00, pos -4: 10 steps qprd 2 forward, abort after 3 edges
    cmd_valid = 2'b10; cmd_ccw = 2'b00; cmd_steps = {16'd10, 16'd0}; cmd_qprd = {16'd2, 16'd0};
    tick();
    cmd_valid = 2'b00;
    repeat (6) tick();
    check("ab_pre_ab", ab(1), 2'b01);
    check("ab_pre_pos", pos[63:32], 32'hFFFF_FFFF);
    check("ab_pre_busy", busy[1], 1'b1);
    abort = 2'b10;
    #1;
    check("ab_ready_mask", cmd_ready[1], 1'b0);
    tick();
    abort = 2'b00;
    check("ab_busy", busy[1], 1'b0);
    check("ab_done", done[1], 1'b0);
    check("ab_ab", ab(1), 2'b01);
    check("ab_pos", pos[63:32], 32'hFFFF_FFFF);
    tick();
    check("ab_done2", done[1], 1'b0);
    check("ab_ready", cmd_ready[1], 1'b1);
    // Next command continues from phase 01
    cmd_valid = 2'b10; cmd_steps = {16'd1, 16'd0}; cmd_qprd = {16'd1, 16'd0};
    tick();
    cmd_valid = 2'b00;
    tick();
    check("cont_ab", ab(1), 2'b00);
    check("cont_pos", pos[63:32], 32'd0);
    check("cont_done", done[1], 1'b1);

    // Reset in mid-run between clock edges
    cmd_valid = 2'b01; cmd_steps = {16'd0, 16'd5}; cmd_qprd = {16'd0, 16'd3};
    tick();
    cmd_valid = 2'b00;
    repeat (3) tick();
    check("mr_ab", ab(0), 2'b01);
    check("mr_pos", pos[31:0], 32'd11);
    check("mr_busy", busy[0], 1'b1);
    #3 rst = 1'b1;
    #1;
    check("mr_rst_a", a, 2'b00);
    check("mr_rst_b", b, 2'b00);
    check("mr_rst_pos", pos, 64'd0);
    check("mr_rst_busy", busy, 2'b00);
    check("mr_rst_done", done, 2'b00);
    #3 rst = 1'b0;
    tick();
    check("mr_ready", cmd_ready, 2'b11);
    check("mr_busy2", busy, 2'b00);
    check("mr_done2", done, 2'b00);
    tick();
    check("mr_done3", done, 2'b00);
    check("mr_ab2", ab(0), 2'b00);
    check("mr_pos2", pos, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/quad_enc_gen.md
QUAD_ENC_GEN -- requirements
Module: quad_enc_gen

Interface
REQ-001 Parameter CH, default 2, number of independent encoder channels (1..8).
REQ-002 Parameter STEPW, default 16, width of per-command step count.
REQ-003 Parameter PRDW, default 16, width of per-command quarter-period in clocks.
REQ-004 Parameter POSW, default 32, width of signed per-channel position counter.
REQ-005 Parameter CPR, default 1024, edges per revolution for index generation (power of two, >=4).
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 cmd_valid  input  CH  per-channel command request.
REQ-009 cmd_ready  output  CH  per-channel command accept.
REQ-010 cmd_ccw  input  CH  direction: 0 = A leads B, 1 = B leads A.
REQ-011 cmd_steps  input  CH*STEPW  quadrature edges to emit, channel i at [i*STEPW +: STEPW].
REQ-012 cmd_qprd  input  CH*PRDW  clocks between edges, channel i at [i*PRDW +: PRDW].
REQ-013 abort  input  CH  per-channel cancel of running command.
REQ-014 a, b  output  CH each  quadrature outputs, registered.
REQ-015 z  output  CH  index output, registered.
REQ-016 busy  output  CH  channel executing a command.
REQ-017 done  output  CH  one-cycle pulse on normal completion.
REQ-018 pos  output  CH*POSW  signed edge position, two's complement.

Function
REQ-019 Each channel shall be an independent FSM with states IDLE and RUN; no interaction between channels.
REQ-020 cmd_ready[i] shall equal (state==IDLE) && !abort[i]; a command is accepted on a cycle with cmd_valid[i] && cmd_ready[i].
REQ-021 On accept, steps, direction and quarter-period shall be latched; later input changes shall not affect the running command.
REQ-022 Accepted cmd_steps==0 shall stay IDLE and pulse done[i] on the next cycle, outputs unchanged.
REQ-023 Accepted cmd_qprd==0 shall be treated as 1.
REQ-024 Accepted nonzero steps shall enter RUN next cycle with busy=1 and timer loaded with qprd.
REQ-025 In RUN the timer shall decrement each clock; on reaching expiry one edge shall occur and the timer reload: first edge exactly qprd cycles after the accept cycle, subsequent edges every qprd cycles.
REQ-026 Edge sequence (a,b) for ccw=0: 00->10->11->01->00; ccw=1: 00->01->11->10->00, continuing from the current phase, not from 00.
REQ-027 Each edge shall change exactly one of a/b and adjust pos by +1 (ccw=0) or -1 (ccw=1), wrapping modulo 2^POSW.
REQ-028 On the edge that exhausts the step count, the FSM shall return to IDLE, busy deassert and done pulse in the same cycle as that edge's output update.
REQ-029 abort[i] in RUN shall return to IDLE next cycle, no done pulse, a/b/pos held at last value; abort in IDLE has no effect.
REQ-030 A new command may be accepted the cycle after done; back-to-back commands shall produce no gap beyond qprd.
REQ-031 a, b, z, busy, done shall be glitch-free flop outputs.

Reset
REQ-032 rst shall asynchronously force all channels to IDLE: a=0, b=0, z=0, busy=0, done=0, pos=0, cmd_ready=1 after release, index counter=0.
REQ-033 rst during RUN shall discard the command without done.

Configuration
REQ-034 Macro QUAD_ENC_GEN_INDEX_EN defined: per-channel index counter modulo CPR tracks edges (up/down with direction); z[i]=1 while counter==0, 0 otherwise.
REQ-035 Macro undefined: index counter not built, z tied 0; all other behaviour identical.

Verification
REQ-036 After reset, ch0 cmd steps=8, qprd=4, ccw=0 -> (a,b) 10,11,01,00,10,11,01,00 at cycles 4,8..32 after accept, pos=8, done at cycle 32.
REQ-037 ch1 steps=4, ccw=1 from phase 00, concurrent with ch0 -> ch1 sequence 01,11,10,00, pos=-4; ch0 unaffected.
REQ-038 steps=0 -> done pulse next cycle, busy never high; qprd=0, steps=2 -> edges 1 cycle apart.
REQ-039 abort after 3 edges of a 10-step command -> idle next cycle, pos=3, no done, next command continues from phase 01.
REQ-040 With QUAD_ENC_GEN_INDEX_EN, CPR=4, steps=8 ccw=0 -> z high after edges 4 and 8; reverse 1 step -> z low, pos=7.
REQ-041 rst asserted mid-RUN between clock edges -> outputs zero immediately, no done, ready=1 after release.
